cd_ram_mp: RTL
==============

// Module: cd_ram_mp
// PURPOSE
//  Multi-page packet buffer between a byte-serial framer (wr_*/rd_* byte ports) and a
//  host memory-mapped bus (mm_*). Generalises the paged frame RAM: configurable bus width,
//  page count, per-page length/flags metadata, pending-page counter, defined same-cycle
//  priorities. One side fills page wr_sel; committed pages queue FIFO-style for rd_sel.
// PARAMETERS
//  A_WIDTH   6  mm word-address width; page = 2**A_WIDTH words
//  MM_BYTES  4  bytes per mm word (1,2,4,8); BA = A_WIDTH+$clog2(MM_BYTES) byte-addr bits
//  N_WIDTH   1  page-index width; PAGES = 2**N_WIDTH (>=2)
//  MM4RD     1  1: mm port reads rd_sel page, byte side writes; 0: mm writes wr_sel, byte reads
// PORTS
//  clk           in   1              clock
//  reset         in   1              synchronous, active-high reset
//  mm_address    in   A_WIDTH        word address inside selected page
//  mm_byteenable in   MM_BYTES       byte lanes for mm_write
//  mm_read       in   1              read strobe
//  mm_readdata   out  8*MM_BYTES     read data, lane k = byte addr {mm_address,k}
//  mm_write      in   1              write strobe (ignored when MM4RD=1)
//  mm_writedata  in   8*MM_BYTES     write data
//  rd_byte       out  8              byte read from page rd_sel
//  rd_addr       in   BA             byte address; rd_en  in 1 read strobe
//  rd_done       in   1              release page rd_sel
//  rd_done_all   in   1              flush all pages
//  wr_byte       in   8              byte for page wr_sel (ignored when MM4RD=0)
//  wr_addr       in   BA             byte address; wr_en  in 1 write strobe
//  switch        in   1              commit page wr_sel
//  wr_flags      in   8              flags stored at commit
//  wr_len        in   BA+1           byte length stored at commit (0..page bytes)
//  rd_flags      out  8              flags of page rd_sel
//  rd_len        out  BA+1           length of page rd_sel
//  unread        out  1              pend_cnt != 0 (combinational)
//  pend_cnt      out  N_WIDTH+1      number of committed, unreleased pages
//  switch_fail   out  1              1-cycle pulse, see BEHAVIOUR
// BEHAVIOUR
//  - Reset: wr_sel=rd_sel=0, dirty=0, pend_cnt=0, switch_fail=0, rd_byte=0, mm_readdata=0,
//    rd_flags=0, rd_len=0. RAM contents undefined (not cleared).
//  - Byte lane = addr[log2(MM_BYTES)-1:0], word = addr[BA-1:log2(MM_BYTES)].
//  - Reads: rd_byte and mm_readdata registered, 1-cycle latency, hold value when strobe low.
//    rd_flags/rd_len registered every cycle from meta[rd_sel] (1-cycle lag after rd_sel moves).
//  - Write side selects wr_sel page, read side rd_sel page; mm side follows MM4RD.
//  - Page state: dirty[PAGES] vector. Writer may never commit into a dirty next page; max
//    pend_cnt = PAGES-1 (one page always owned by writer).
//  - Priority per cycle: rd_done_all > rd_done > switch.
//  - rd_done_all: wr_sel=rd_sel=0, dirty=0, pend_cnt=0, switch_fail=0; same-cycle switch/rd_done ignored.
//  - rd_done with dirty[rd_sel]=1: clear it, rd_sel+1 (wraps mod PAGES). Else ignored.
//  - switch: "next free" evaluated after same-cycle rd_done, i.e. if rd_done frees page
//    wr_sel+1 in that cycle the switch succeeds. Success: dirty[wr_sel]=1, meta[wr_sel]=
//    {wr_flags,wr_len}, wr_sel+1. Full: no state change, switch_fail=1 next cycle.
//  - pend_cnt tracks +1 commit / -1 release; simultaneous -> unchanged.
//  - Same-cycle write and read of one address: read returns old data.
//  - wr_len > page bytes: stored value saturates to 2**BA.
// CONFIGURATION
//  CD_RAM_DROP_OLDEST_EN defined: switch on full never rejects; oldest page dropped:
//    rd_sel+1, dirty[old rd_sel]=0, commit proceeds, pend_cnt unchanged, switch_fail
//    still pulses (reports loss). Reader mid-page sees data change; host must recheck.
//  Undefined: full switch rejected as above; page contents and pend_cnt untouched.
// TESTING
//  1 reset, PAGES=2: write 0x11..0x14 to addr 0..3, switch len=4 flags=0x5A -> unread=1,
//    pend_cnt=1, mm read addr0 -> 0x14131211 next cycle, rd_len=4, rd_flags=0x5A.
//  2 PAGES=4: 3 switches no rd_done -> pend_cnt=3; 4th switch -> switch_fail pulse 1 cycle,
//    wr_sel stays 3 (with DROP_OLDEST_EN: rd_sel=1, pend_cnt=3, switch_fail pulse).
//  3 full, switch and rd_done same cycle -> switch accepted, switch_fail=0, pend_cnt unchanged.
//  4 rd_done_all with switch+rd_done same cycle -> all pointers 0, pend_cnt=0, unread=0.
//  5 MM4RD=0, MM_BYTES=2: mm_write 0xBEEF be=2'b10 on 0x0000 word -> rd_byte addr1=0xBE,
//    addr0 unchanged; pointer wrap 0->PAGES-1->0 verified over 2*PAGES commits.
//  6 reset asserted mid-sequence (pend_cnt=2) -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/cd_ram_mp.sv
// rtl/cd_ram_mp.sv - multi-page packet buffer between a byte-serial framer and a memory-mapped host
//
// Purpose: PAGES = 2**N_WIDTH pages of 2**A_WIDTH words (MM_BYTES bytes each).
// The write side fills page wr_sel; a switch commits it with {flags,len} metadata.
// Committed pages queue FIFO-style for the read side at page rd_sel.
// MM4RD=1: the mm port reads rd_sel and the byte port writes wr_sel.
// MM4RD=0: the mm port writes and reads wr_sel and the byte port reads rd_sel.
// Optional feature macro: CD_RAM_DROP_OLDEST_EN. When defined, a switch into a full buffer
// drops the oldest pending page instead of being rejected.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   mm_address/_byteenable word address in page, write lanes
//   mm_read/mm_readdata    read strobe, registered read data (lane k = byte {addr,k})
//   mm_write/mm_writedata  write strobe/data (only used when MM4RD=0)
//   rd_addr/rd_en/rd_byte  byte read from page rd_sel (registered)
//   rd_done, rd_done_all   release page rd_sel, flush all pages
//   wr_addr/wr_en/wr_byte  byte write into page wr_sel (only used when MM4RD=1)
//   switch/wr_flags/wr_len commit page wr_sel with metadata
//   rd_flags/rd_len        registered metadata of page rd_sel
//   unread, pend_cnt       pending-page indication and count
//   switch_fail            one-cycle pulse after a switch into a full buffer
module cd_ram_mp #(
   parameter int A_WIDTH  = 6,
   parameter int MM_BYTES = 4,
   parameter int N_WIDTH  = 1,
   parameter bit MM4RD    = 1'b1,
   localparam int LB      = $clog2(MM_BYTES),
   localparam int BA      = A_WIDTH + LB
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [A_WIDTH-1:0]    mm_address,
   input  logic [MM_BYTES-1:0]   mm_byteenable,
   input  logic                  mm_read,
   output logic [8*MM_BYTES-1:0] mm_readdata,
   input  logic                  mm_write,
   input  logic [8*MM_BYTES-1:0] mm_writedata,
   output logic [7:0]            rd_byte,
   input  logic [BA-1:0]         rd_addr,
   input  logic                  rd_en,
   input  logic                  rd_done,
   input  logic                  rd_done_all,
   input  logic [7:0]            wr_byte,
   input  logic [BA-1:0]         wr_addr,
   input  logic                  wr_en,
   input  logic                  switch,
   input  logic [7:0]            wr_flags,
   input  logic [BA:0]           wr_len,
   output logic [7:0]            rd_flags,
   output logic [BA:0]           rd_len,
   output logic                  unread,
   output logic [N_WIDTH:0]      pend_cnt,
   output logic                  switch_fail
);

   localparam int PAGES = 2**N_WIDTH;
   localparam int WORDS = 2**A_WIDTH;
   localparam int DW    = 8*MM_BYTES;
   localparam int LW    = (LB > 0) ? LB : 1;
   localparam int IW    = N_WIDTH + A_WIDTH;
   localparam logic [BA:0] PAGE_LEN = {1'b1, {BA{1'b0}}};

   // Page RAM, index = {page, word}
   logic [DW-1:0] mem [PAGES*WORDS];

   logic [N_WIDTH-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, nxt;
   logic [PAGES-1:0]   dirty_q, dirty_d;
   logic [N_WIDTH:0]   pend_q, pend_d;
   logic               fail_q, fail_d;
   logic               rel, commit, drop;
   logic [7:0]         flags_q [PAGES];
   logic [BA:0]        len_q [PAGES];
   logic [7:0]         rd_flags_q, rd_byte_q;
   logic [BA:0]        rd_len_q, len_sat;
   logic [DW-1:0]      mm_rdata_q;

   logic               w_en;
   logic [IW-1:0]      w_idx;
   logic [MM_BYTES-1:0] w_be;
   logic [DW-1:0]      w_data;
   logic [N_WIDTH-1:0] mm_pg;

   logic unused_inputs;
   assign unused_inputs = ^{wr_byte, wr_addr, wr_en, mm_write, mm_writedata, mm_byteenable};

   function automatic logic [A_WIDTH-1:0] word_of(input logic [BA-1:0] a);
      return A_WIDTH'(a >> LB);
   endfunction

   function automatic logic [LW-1:0] lane_of(input logic [BA-1:0] a);
      return LW'(a) & LW'(MM_BYTES - 1);
   endfunction

   // Single RAM write port; its source is chosen by which side owns writing
   generate
      if (MM4RD) begin : g_byte_wr
         always_comb begin
            w_en   = wr_en;
            w_idx  = {wr_sel_q, word_of(wr_addr)};
            w_be   = MM_BYTES'(1) << lane_of(wr_addr);
            w_data = {MM_BYTES{wr_byte}};
         end
      end else begin : g_mm_wr
         always_comb begin
            w_en   = mm_write;
            w_idx  = {wr_sel_q, mm_address};
            w_be   = mm_byteenable;
            w_data = mm_writedata;
         end
      end
   endgenerate

   // The mm port works on whichever page its side owns
   assign mm_pg = MM4RD ? rd_sel_q : wr_sel_q;

   always_ff @(posedge clk) begin
      if (w_en) begin
         for (int k = 0; k < MM_BYTES; k++) begin
            if (w_be[k]) mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
         end
      end
   end

   // Registered reads; a same-cycle write is not forwarded, so old data is returned
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_byte_q  <= '0;
         mm_rdata_q <= '0;
      end else begin
         if (mm_read) mm_rdata_q <= mem[{mm_pg, mm_address}];
         if (rd_en)   rd_byte_q  <= 8'(mem[{rd_sel_q, word_of(rd_addr)}] >> {lane_of(rd_addr), 3'b000});
      end
   end

   assign len_sat = (wr_len > PAGE_LEN) ? PAGE_LEN : wr_len;

   // Page bookkeeping: flush beats release, and release is applied before the
   // switch looks for a free successor page.
   always_comb begin
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      dirty_d  = dirty_q;
      pend_d   = pend_q;
      fail_d   = 1'b0;
      rel      = 1'b0;
      commit   = 1'b0;
      drop     = 1'b0;
      nxt      = wr_sel_q + N_WIDTH'(1);
      if (rd_done_all) begin
         wr_sel_d = '0;
         rd_sel_d = '0;
         dirty_d  = '0;
         pend_d   = '0;
      end else begin
         if (rd_done && dirty_q[rd_sel_q]) begin
            rel               = 1'b1;
            dirty_d[rd_sel_q] = 1'b0;
            rd_sel_d          = rd_sel_q + N_WIDTH'(1);
         end
         if (switch) begin
            if (!dirty_d[nxt]) begin
               commit = 1'b1;
            end else begin
               fail_d = 1'b1;
`ifdef CD_RAM_DROP_OLDEST_EN
               // A dirty successor is always the oldest pending page; sacrifice it
               drop              = 1'b1;
               commit            = 1'b1;
               dirty_d[rd_sel_q] = 1'b0;
               rd_sel_d          = rd_sel_q + N_WIDTH'(1);
`endif
            end
            if (commit) begin
               dirty_d[wr_sel_q] = 1'b1;
               wr_sel_d          = nxt;
            end
         end
         pend_d = pend_q + (N_WIDTH+1)'(commit) - (N_WIDTH+1)'(rel) - (N_WIDTH+1)'(drop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_sel_q   <= '0;
         rd_sel_q   <= '0;
         dirty_q    <= '0;
         pend_q     <= '0;
         fail_q     <= 1'b0;
         rd_flags_q <= '0;
         rd_len_q   <= '0;
         for (int p = 0; p < PAGES; p++) begin
            flags_q[p] <= '0;
            len_q[p]   <= '0;
         end
      end else begin
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         dirty_q    <= dirty_d;
         pend_q     <= pend_d;
         fail_q     <= fail_d;
         rd_flags_q <= flags_q[rd_sel_q];
         rd_len_q   <= len_q[rd_sel_q];
         if (commit) begin
            flags_q[wr_sel_q] <= wr_flags;
            len_q[wr_sel_q]   <= len_sat;
         end
      end
   end

   assign mm_readdata = mm_rdata_q;
   assign rd_byte     = rd_byte_q;
   assign rd_flags    = rd_flags_q;
   assign rd_len      = rd_len_q;
   assign pend_cnt    = pend_q;
   assign unread      = (pend_q != '0);
   assign switch_fail = fail_q;

endmodule
